// File: rtl/alu_defs.sv
// alu_defs: state and opcode encodings shared by the ALU arithmetic path.
package alu_defs;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract sequencer, LSB first through one full adder.
module serial_adder_ctrl
  import alu_defs::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         c_out,
  output logic         overflow
);
  localparam int CNT_W = $clog2(N + 1);
  state_t state;
  logic [N-1:0] a_sr, b_sr;
  logic [CNT_W-1:0] cnt;
  logic carry, fa_s, fa_c;
  full_adder u_fa (
    .a (a_sr[0]),
    .b (b_sr[0]),
    .ci(carry),
    .s (fa_s),
    .co(fa_c)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      cnt      <= '0;
      carry    <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
    end else
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= sub == OP_SUB ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          result <= {fa_s, result[N-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          // carry still holds the carry into the MSB on the final bit
          if (cnt == CNT_W'(N - 1)) begin
            c_out    <= fa_c;
            overflow <= carry ^ fa_c;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: randomized and directed checks against an arithmetic reference model.
module tb_serial_adder_ctrl;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, sub = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic busy, done, c_out, overflow;
  logic [N-1:0] result;
  int total = 0, passed = 0;

  serial_adder_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .c_out(c_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // returns {overflow, c_out, result} from plain integer arithmetic
  function automatic logic [N+1:0] ref_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    int ux = int'(x), uy = int'(y);
    int sx = int'($signed(x)), sy = int'($signed(y));
    int ur = s ? ux - uy : ux + uy;
    int sr = s ? sx - sy : sx + sy;
    logic co = s ? (ux >= uy) : (ur >= (1 << N));
    logic ov = (sr > (1 << (N - 1)) - 1) || (sr < -(1 << (N - 1)));
    return {ov, co, N'(ur)};
  endfunction

  // compare process: model of acceptance/latency plus per-cycle output checks
  initial begin
    int k = 0, acc = -1000, ready = 0;
    logic [N+1:0] exp_v = '0;
    bit eb, ed;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        acc = -1000;
        ready = 0;
        exp_v = '0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_cout", 32'(c_out), 0);
        chk("rst_ovf", 32'(overflow), 0);
        continue;
      end
      k++;
      if (start && k >= ready) begin
        acc = k;
        ready = k + N + 2;
        exp_v = ref_op(a, b, sub);
      end
      #1;
      eb = (k >= acc) && (k < acc + N);
      ed = (k == acc + N);
      chk("busy", 32'(busy), 32'(eb));
      chk("done", 32'(done), 32'(ed));
      if (!eb) begin
        chk("result", 32'(result), 32'(exp_v[N-1:0]));
        chk("c_out", 32'(c_out), 32'(exp_v[N]));
        chk("overflow", 32'(overflow), 32'(exp_v[N+1]));
      end
    end
  end

  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = N'($urandom); b = N'($urandom); sub = 1'($urandom);
  endtask

  typedef struct { logic [N-1:0] x, y; logic s; logic [N+1:0] e; } vec_t;
  vec_t vecs[5] = '{
    '{8'h3C, 8'h5A, 1'b0, {1'b1, 1'b0, 8'h96}},
    '{8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00}},
    '{8'h05, 8'h07, 1'b1, {1'b0, 1'b0, 8'hFE}},
    '{8'h80, 8'h01, 1'b1, {1'b1, 1'b1, 8'h7F}},
    '{8'h00, 8'h00, 1'b0, {1'b0, 1'b0, 8'h00}}
  };

  initial begin
    foreach (vecs[i]) chk("model_pin", 32'(ref_op(vecs[i].x, vecs[i].y, vecs[i].s)), 32'(vecs[i].e));
    chk("model_sub0", 32'(ref_op(8'h5A, 8'h00, 1'b1)), 32'({1'b0, 1'b1, 8'h5A}));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      issue(vecs[i].x, vecs[i].y, vecs[i].s);
      repeat (N + 2) @(negedge clk);
    end
    @(negedge clk);
    start = 1'b1;
    repeat (50) begin
      a = N'($urandom); b = N'($urandom); sub = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (N + 2) @(negedge clk);
    issue(8'hA5, 8'h3C, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(8'h01, 8'h01, 1'b0);
    repeat (N + 3) @(negedge clk);
    repeat (400) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a = N'($urandom); b = N'($urandom); sub = 1'($urandom);
    end
    start = 1'b0;
    repeat (N + 3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
